// File: rtl/proc_pkg.sv
// Shared opcode, state, ALU and PC-select encodings for the multicycle controller,
// plus the per-state Moore control table.
package proc_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BALN   = 6'b011011;
    localparam logic [5:0] OP_BGTZAL = 6'b011100;
    localparam logic [5:0] OP_BRNV   = 6'b011101;
    localparam logic [5:0] OP_J      = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_ORI, C_LW, C_SW, C_BEQ, C_BALN, C_BGTZAL, C_BRNV, C_J, C_ILLEGAL
    } iclass_t;

    // fetch/branch/jump mark the states whose strobes are gated by mem_ready or flags.
    typedef struct packed {
        logic       fetch;
        logic       branch;
        logic       jump;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic       ori;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(state_t st, iclass_t cls);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.fetch    = 1'b1;
                c.memread  = 1'b1;
                c.alusrcb  = SRCB_FOUR;
                c.pcsource = PCSRC_ALU;
            end
            S_DECODE: c.alusrcb = SRCB_BOFF;
            S_EXEC_R: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REG;
                c.aluop   = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.ori     = 1'b1;
                c.aluop   = ALUOP_OR;
            end
            S_ADDR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_ADD;
            end
            S_MEM_RD: begin
                c.iord    = 1'b1;
                c.memread = 1'b1;
            end
            S_MEM_WR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_WB_ALU: begin
                c.regwrite = 1'b1;
                c.regdst   = (cls == C_RTYPE);
            end
            S_WB_MEM: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_BRANCH: begin
                c.branch   = 1'b1;
                c.alusrca  = 1'b1;
                c.aluop    = ALUOP_SUB;
                c.pcsource = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.jump     = 1'b1;
                c.pcsource = PCSRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier: instruction class, whether the class can link
// (write PC+4 to r31), and whether the opcode is unsupported.
module mc_decode
    import proc_pkg::*;
(
    input  logic [5:0] opcode_i,
    output iclass_t    cls_o,
    output logic       link_cap_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o = C_ILLEGAL;
        case (opcode_i)
            OP_RTYPE:  cls_o = C_RTYPE;
            OP_ORI:    cls_o = C_ORI;
            OP_LW:     cls_o = C_LW;
            OP_SW:     cls_o = C_SW;
            OP_BEQ:    cls_o = C_BEQ;
            OP_BALN:   cls_o = C_BALN;
            OP_BGTZAL: cls_o = C_BGTZAL;
            OP_BRNV:   cls_o = C_BRNV;
            OP_J:      cls_o = C_J;
            default:   cls_o = C_ILLEGAL;
        endcase
    end

    assign link_cap_o = (cls_o == C_BALN) || (cls_o == C_BGTZAL);
    assign illegal_o  = (cls_o == C_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes, counts retired instructions and traps on illegal opcodes.
module multicycle_control
    import proc_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic                zout,
    input  logic                nflag,
    input  logic                vflag,
    input  logic                mem_ready,
    output logic                irwrite,
    output logic                pcwrite,
    output logic                iord,
    output logic                memread,
    output logic                memwrite,
    output logic                memtoreg,
    output logic                regdst,
    output logic                regwrite,
    output logic                alusrca,
    output logic                ori,
    output logic                link,
    output logic [1:0]          alusrcb,
    output logic [1:0]          aluop,
    output logic [1:0]          pcsource,
    output logic [3:0]          state,
    output logic                trap,
    output logic [RETIRE_W-1:0] retired
);

    state_t              state_q, state_d;
    iclass_t             cls_q, cls_d;
    logic                link_cap_q, link_cap_d;
    ctrl_t               ctrl_q, ctrl_g;
    logic                trap_q;
    logic [RETIRE_W-1:0] retired_q;
    logic                taken;

    iclass_t dec_cls;
    logic    dec_link_cap;
    logic    dec_illegal;

    mc_decode u_decode (
        .opcode_i   (opcode),
        .cls_o      (dec_cls),
        .link_cap_o (dec_link_cap),
        .illegal_o  (dec_illegal)
    );

    // Instruction class is captured in DECODE so later states do not depend on opcode.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        link_cap_d = link_cap_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                cls_d      = dec_cls;
                link_cap_d = dec_link_cap;
                if (dec_illegal) begin
                    state_d = S_TRAP;
                end else begin
                    case (dec_cls)
                        C_RTYPE:    state_d = S_EXEC_R;
                        C_ORI:      state_d = S_EXEC_I;
                        C_LW, C_SW: state_d = S_ADDR;
                        C_J:        state_d = S_JUMP;
                        default:    state_d = S_BRANCH;
                    endcase
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_ADDR:   state_d = (cls_q == C_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR: if (mem_ready) state_d = S_FETCH;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (cls_q)
            C_BEQ:    taken = zout;
            C_BALN:   taken = nflag;
            C_BGTZAL: taken = ~zout & ~nflag;
            C_BRNV:   taken = ~vflag;
            default:  taken = 1'b0;
        endcase
    end

    // ctrl_q holds the Moore controls of the state being entered, so it tracks state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            cls_q      <= C_ILLEGAL;
            link_cap_q <= 1'b0;
            ctrl_q     <= ctrl_of(S_FETCH, C_ILLEGAL);
            trap_q     <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            link_cap_q <= link_cap_d;
            ctrl_q     <= ctrl_of(state_d, cls_d);
            trap_q     <= trap_q | (state_d == S_TRAP);
            if (state_d == S_FETCH && state_q != S_FETCH) begin
                retired_q <= retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Nothing may write memory, registers or PC while reset is held.
    assign ctrl_g   = reset ? '0 : ctrl_q;

    assign irwrite  = ctrl_g.fetch & mem_ready;
    assign pcwrite  = (ctrl_g.fetch & mem_ready) | ctrl_g.jump | (ctrl_g.branch & taken);
    assign link     = ctrl_g.branch & taken & link_cap_q;
    assign regwrite = ctrl_g.regwrite | link;
    assign iord     = ctrl_g.iord;
    assign memread  = ctrl_g.memread;
    assign memwrite = ctrl_g.memwrite;
    assign memtoreg = ctrl_g.memtoreg;
    assign regdst   = ctrl_g.regdst;
    assign alusrca  = ctrl_g.alusrca;
    assign ori      = ctrl_g.ori;
    assign alusrcb  = ctrl_g.alusrcb;
    assign aluop    = ctrl_g.aluop;
    assign pcsource = ctrl_g.pcsource;
    assign state    = state_q;
    assign trap     = trap_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction sequences push
// hand-computed per-cycle expectations; a negedge monitor pops and compares.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zout, nflag, vflag, mem_ready;
    logic        irwrite, pcwrite, iord, memread, memwrite, memtoreg, regdst;
    logic        regwrite, alusrca, ori, link;
    logic [1:0]  alusrcb, aluop, pcsource;
    logic [3:0]  state;
    logic        trap;
    logic [31:0] retired;

    always #5 clk = ~clk;

    multicycle_control #(.RETIRE_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zout(zout), .nflag(nflag),
        .vflag(vflag), .mem_ready(mem_ready), .irwrite(irwrite), .pcwrite(pcwrite),
        .iord(iord), .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca), .ori(ori), .link(link),
        .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .state(state),
        .trap(trap), .retired(retired)
    );

    // Vector: {irwrite,pcwrite,iord,memread,memwrite,memtoreg,regdst,regwrite,alusrca,ori,link,
    //          alusrcb,aluop,pcsource,state,trap}
    localparam logic [21:0] E_F      = {11'b11010000000, 2'b01, 2'b00, 2'b00, 4'd0,  1'b0};
    localparam logic [21:0] E_FW     = {11'b00010000000, 2'b01, 2'b00, 2'b00, 4'd0,  1'b0};
    localparam logic [21:0] E_D      = {11'b00000000000, 2'b11, 2'b00, 2'b00, 4'd1,  1'b0};
    localparam logic [21:0] E_XR     = {11'b00000000100, 2'b00, 2'b10, 2'b00, 4'd2,  1'b0};
    localparam logic [21:0] E_XI     = {11'b00000000110, 2'b10, 2'b11, 2'b00, 4'd3,  1'b0};
    localparam logic [21:0] E_AD     = {11'b00000000100, 2'b10, 2'b00, 2'b00, 4'd4,  1'b0};
    localparam logic [21:0] E_MR     = {11'b00110000000, 2'b00, 2'b00, 2'b00, 4'd5,  1'b0};
    localparam logic [21:0] E_MW     = {11'b00101000000, 2'b00, 2'b00, 2'b00, 4'd6,  1'b0};
    localparam logic [21:0] E_WBR    = {11'b00000011000, 2'b00, 2'b00, 2'b00, 4'd7,  1'b0};
    localparam logic [21:0] E_WBI    = {11'b00000001000, 2'b00, 2'b00, 2'b00, 4'd7,  1'b0};
    localparam logic [21:0] E_WBM    = {11'b00000101000, 2'b00, 2'b00, 2'b00, 4'd8,  1'b0};
    localparam logic [21:0] E_BTL    = {11'b01000001101, 2'b00, 2'b01, 2'b01, 4'd9,  1'b0};
    localparam logic [21:0] E_BT     = {11'b01000000100, 2'b00, 2'b01, 2'b01, 4'd9,  1'b0};
    localparam logic [21:0] E_BN     = {11'b00000000100, 2'b00, 2'b01, 2'b01, 4'd9,  1'b0};
    localparam logic [21:0] E_J      = {11'b01000000000, 2'b00, 2'b00, 2'b10, 4'd10, 1'b0};
    localparam logic [21:0] E_TR     = {11'b00000000000, 2'b00, 2'b00, 2'b00, 4'd11, 1'b1};
    localparam logic [21:0] E_RST0   = {11'b00000000000, 2'b00, 2'b00, 2'b00, 4'd0,  1'b0};
    localparam logic [21:0] E_RST_TR = {11'b00000000000, 2'b00, 2'b00, 2'b00, 4'd11, 1'b1};
    localparam logic [21:0] E_RST_MW = {11'b00000000000, 2'b00, 2'b00, 2'b00, 4'd6,  1'b0};

    typedef struct {
        string       tag;
        logic [21:0] sig;
        logic [31:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   applied    = 0;
    int   miscompares = 0;

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [21:0] act;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {irwrite, pcwrite, iord, memread, memwrite, memtoreg, regdst, regwrite,
                   alusrca, ori, link, alusrcb, aluop, pcsource, state, trap};
            applied++;
            if (act !== e.sig || retired !== e.ret) begin
                miscompares++;
                $display("FAIL %s: got sig=%b retired=%0d, required sig=%b retired=%0d",
                         e.tag, act, retired, e.sig, e.ret);
            end else begin
                $display("ok   %s: sig=%b retired=%0d", e.tag, act, retired);
            end
        end
    end

    task automatic cyc(input string tag, input logic rdy, input logic rst,
                       input logic z, input logic n, input logic v,
                       input logic [21:0] e, input logic [31:0] r);
        mem_ready = rdy;
        reset     = rst;
        zout      = z;
        nflag     = n;
        vflag     = v;
        sb_q.push_back('{tag, e, r});
        @(posedge clk);
        #1;
    endtask

    // Three-cycle branch: FETCH, DECODE, BRANCH with flags applied in BRANCH.
    task automatic branch(input string tag, input logic [5:0] op,
                          input logic z, input logic n, input logic v,
                          input logic [21:0] eb, input logic [31:0] r);
        opcode = op;
        cyc({tag, "_fetch"},  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F, r);
        cyc({tag, "_decode"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_D, r);
        cyc({tag, "_branch"}, 1'b1, 1'b0, z, n, v, eb, r);
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        zout = 1'b0; nflag = 1'b0; vflag = 1'b0;
        @(posedge clk); #1;
        cyc("reset_hold", 1, 1, 0, 0, 0, E_RST0, 0);

        opcode = 6'b100011;
        cyc("lw_fetch",  1, 0, 0, 0, 0, E_F,   0);
        cyc("lw_decode", 1, 0, 0, 0, 0, E_D,   0);
        cyc("lw_addr",   1, 0, 0, 0, 0, E_AD,  0);
        cyc("lw_memrd",  1, 0, 0, 0, 0, E_MR,  0);
        cyc("lw_wbmem",  1, 0, 0, 0, 0, E_WBM, 0);

        opcode = 6'b101011;
        cyc("sw_fetch",   1, 0, 0, 0, 0, E_F,  1);
        cyc("sw_decode",  1, 0, 0, 0, 0, E_D,  1);
        cyc("sw_addr",    1, 0, 0, 0, 0, E_AD, 1);
        cyc("sw_memwr_w1",0, 0, 0, 0, 0, E_MW, 1);
        cyc("sw_memwr_w2",0, 0, 0, 0, 0, E_MW, 1);
        cyc("sw_memwr_ok",1, 0, 0, 0, 0, E_MW, 1);

        opcode = 6'b000000;
        cyc("r_fetch",  1, 0, 0, 0, 0, E_F,   2);
        cyc("r_decode", 1, 0, 0, 0, 0, E_D,   2);
        cyc("r_exec",   1, 0, 0, 0, 0, E_XR,  2);
        cyc("r_wb",     1, 0, 0, 0, 0, E_WBR, 2);

        opcode = 6'b001101;
        cyc("ori_fetch_wait", 0, 0, 0, 0, 0, E_FW,  3);
        cyc("ori_fetch",      1, 0, 0, 0, 0, E_F,   3);
        cyc("ori_decode",     1, 0, 0, 0, 0, E_D,   3);
        cyc("ori_exec",       1, 0, 0, 0, 0, E_XI,  3);
        cyc("ori_wb",         1, 0, 0, 0, 0, E_WBI, 3);

        branch("beq_z1",    6'b000100, 1, 0, 0, E_BT,  4);
        branch("beq_z0",    6'b000100, 0, 0, 0, E_BN,  5);
        branch("baln_n1",   6'b011011, 0, 1, 0, E_BTL, 6);
        branch("baln_n0",   6'b011011, 0, 0, 0, E_BN,  7);
        branch("bgtzal_z0", 6'b011100, 0, 0, 0, E_BTL, 8);
        branch("bgtzal_z1", 6'b011100, 1, 0, 0, E_BN,  9);
        branch("brnv_v1",   6'b011101, 0, 0, 1, E_BN,  10);
        branch("brnv_v0",   6'b011101, 0, 0, 0, E_BT,  11);

        opcode = 6'b000010;
        cyc("j_fetch",  1, 0, 0, 0, 0, E_F, 12);
        cyc("j_decode", 1, 0, 0, 0, 0, E_D, 12);
        cyc("j_jump",   1, 0, 0, 0, 0, E_J, 12);

        opcode = 6'b111111;
        cyc("ill_fetch",  1, 0, 0, 0, 0, E_F,  13);
        cyc("ill_decode", 1, 0, 0, 0, 0, E_D,  13);
        cyc("ill_trap1",  1, 0, 0, 0, 0, E_TR, 13);
        cyc("ill_trap2",  0, 0, 0, 0, 0, E_TR, 13);
        cyc("ill_trap3",  1, 0, 0, 0, 0, E_TR, 13);
        cyc("ill_reset",  1, 1, 0, 0, 0, E_RST_TR, 13);

        opcode = 6'b101011;
        cyc("swr_fetch",  1, 0, 0, 0, 0, E_F,  0);
        cyc("swr_decode", 1, 0, 0, 0, 0, E_D,  0);
        cyc("swr_addr",   1, 0, 0, 0, 0, E_AD, 0);
        cyc("swr_memwr",  0, 0, 0, 0, 0, E_MW, 0);
        cyc("swr_reset",  1, 1, 0, 0, 0, E_RST_MW, 0);

        opcode = 6'b000010;
        cyc("j2_fetch",  1, 0, 0, 0, 0, E_F, 0);
        cyc("j2_decode", 1, 0, 0, 0, 0, E_D, 0);
        cyc("j2_jump",   1, 0, 0, 0, 0, E_J, 0);
        cyc("final_fetch", 1, 0, 0, 0, 0, E_F, 1);

        @(posedge clk); #1;
        @(posedge clk); #1;
        applied++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter RETIRE_W, default 32, width of retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  6  instruction bits 31:26 from the instruction register.
REQ-005 SHALL have port zout  input  1  ALU zero flag, combinational from current EXEC/BRANCH compare.
REQ-006 SHALL have ports nflag, vflag  input  1 each  registered ALU negative/overflow flags.
REQ-007 SHALL have port mem_ready  input  1  memory access complete this cycle.
REQ-008 SHALL have ports irwrite, pcwrite, iord, memread, memwrite, memtoreg, regdst, regwrite, alusrca, ori, link  output  1 each  datapath strobes/selects.
REQ-009 SHALL have ports alusrcb, aluop, pcsource  output  2 each  ALU-B select, ALU op class, next-PC select.
REQ-010 SHALL have port state  output  4  current state encoding.
REQ-011 SHALL have port trap  output  1  illegal opcode seen; sticky.
REQ-012 SHALL have port retired  output  RETIRE_W  count of completed instructions.

Function
REQ-013 SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.
REQ-014 FETCH: iord=0, memread=1, alusrca=0, alusrcb=01 (+4), pcsource=00; irwrite=pcwrite=1 only in the cycle mem_ready=1; otherwise hold FETCH.
REQ-015 DECODE: alusrcb=11 (branch offset precompute); next state by opcode: 000000->EXEC_R, 001101->EXEC_I, 100011/101011->ADDR, 000100/011011/011100/011101->BRANCH, 000010->JUMP, any other->TRAP.
REQ-016 EXEC_R: alusrca=1, alusrcb=00, aluop=10 -> WB_ALU; EXEC_I: alusrca=1, alusrcb=10, ori=1, aluop=11 -> WB_ALU.
REQ-017 ADDR: alusrca=1, alusrcb=10, aluop=00 -> MEM_RD (lw) or MEM_WR (sw).
REQ-018 MEM_RD: iord=1, memread=1, hold until mem_ready -> WB_MEM; MEM_WR: iord=1, memwrite=1, hold until mem_ready -> FETCH.
REQ-019 WB_ALU: regwrite=1, memtoreg=0, regdst=1 for R-type else 0 -> FETCH; WB_MEM: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
REQ-020 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pcwrite=taken; taken = beq: zout; baln (011011): nflag; bgtzal (011100): ~zout & ~nflag; brnv (011101): ~vflag -> FETCH.
REQ-021 BRANCH for baln/bgtzal when taken SHALL also assert link=1 and regwrite=1 (write PC+4 to register 31); beq/brnv never link.
REQ-022 JUMP: pcsource=10, pcwrite=1 -> FETCH.
REQ-023 TRAP: all strobes 0, trap=1, remain until reset.
REQ-024 Latency (mem_ready always 1): beq/baln/bgtzal/brnv/j 3 cycles, R-type/ori/sw 4, lw 5; each mem_ready=0 cycle adds one.
REQ-025 retired SHALL increment by 1 on the last cycle of every instruction (transition into FETCH from a non-reset state), wrapping modulo 2^RETIRE_W; TRAP does not increment.
REQ-026 All outputs not named for a state SHALL be 0 in that state; outputs are Moore except irwrite/pcwrite (FETCH, gated by mem_ready) and pcwrite/link/regwrite in BRANCH (gated by flags).
REQ-027 pcwrite and memwrite SHALL never be asserted in the same cycle.

Reset
REQ-028 reset=1 at a posedge SHALL force state=FETCH, trap=0, retired=0 next cycle, overriding any other transition, including mid-MEM_WR or in TRAP.
REQ-029 While reset=1, all strobe outputs SHALL be 0 (no memory or register write during reset).

Structure
REQ-030 Opcode constants, state encoding, aluop/alusrcb/pcsource codes SHALL live in shared package proc_pkg.
REQ-031 Opcode-to-class decode SHALL be sub-module mc_decode (combinational: opcode -> class, link-capable, illegal).

Verification
REQ-032 lw (100011), mem_ready=1 -> states FETCH,DECODE,ADDR,MEM_RD,WB_MEM; regwrite=memtoreg=1 in cycle 5; retired 0->1.
REQ-033 sw with mem_ready low 2 cycles in MEM_WR -> memwrite held 3 cycles, single FETCH after, total 6 cycles.
REQ-034 baln with nflag=1 -> BRANCH cycle pcwrite=link=regwrite=1; nflag=0 -> all three 0; bgtzal zout=0,nflag=0 -> taken.
REQ-035 brnv with vflag=1 -> not taken; vflag=0 -> pcwrite=1, link=0.
REQ-036 opcode 111111 -> TRAP, trap=1, retired frozen; reset pulse -> FETCH, trap=0, retired=0.
REQ-037 reset asserted during MEM_WR -> next cycle FETCH, memwrite=0, no extra retired increment.
